// File: rtl/bus_str_serializer.sv
// rtl/bus_str_serializer.sv - bus write to stream serializer with a DEPTH-entry packet FIFO
// Optional completed-packet counter output str_cnt: define BUS_STR_SERIALIZER_CNT_EN.
module bus_str_serializer #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int SW        = 8,
    parameter int DEPTH     = 2,
    parameter int MSB_FIRST = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bus_vld,
    input  logic [AW-1:0]              bus_adr,
    input  logic [DW-1:0]              bus_dat,
    output logic                       bus_rdy,
    output logic [$clog2(DEPTH+1)-1:0] bus_ocp,
    output logic                       str_vld,
    output logic [SW-1:0]              str_bus,
    output logic                       str_lst,
    input  logic                       str_rdy
`ifdef BUS_STR_SERIALIZER_CNT_EN
    ,
    output logic [15:0]                str_cnt
`endif
);

    localparam int PW    = AW + DW;
    localparam int N     = PW / SW;
    localparam int BW    = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCP_W = $clog2(DEPTH + 1);

    if ((PW % SW) != 0) begin : g_bad_sw
        $error("bus_str_serializer: AW+DW must be a multiple of SW");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("bus_str_serializer: DEPTH must be at least 1");
    end

    logic [PW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [BW-1:0]    beat;
    logic [BW-1:0]    sel;
    int unsigned      sel_idx;
    logic [PW-1:0]    head;
    logic             full;
    logic             empty;
    logic             bus_trn;
    logic             str_trn;
    logic             pop;

    assign full    = (bus_ocp == OCP_W'(DEPTH));
    assign empty   = (bus_ocp == '0);
    assign str_vld = ~empty;
    assign str_lst = str_vld & (beat == BW'(N - 1));
    assign str_trn = str_vld & str_rdy;
    assign pop     = str_trn & str_lst;
    // The final beat frees its slot this cycle, so a full FIFO can still accept.
    assign bus_rdy = ~full | pop;
    assign bus_trn = bus_vld & bus_rdy;
    assign head    = mem[rd_ptr];

    always_comb begin
        sel     = (MSB_FIRST != 0) ? (BW'(N - 1) - beat) : beat;
        sel_idx = 32'(sel);
        str_bus = head[sel_idx*SW +: SW];
    end

    always_ff @(posedge clk) begin
        if (bus_trn) begin
            mem[wr_ptr] <= {bus_adr, bus_dat};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            beat    <= '0;
            bus_ocp <= '0;
        end else begin
            if (bus_trn) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                beat   <= '0;
            end else if (str_trn) begin
                beat <= beat + 1'b1;
            end
            case ({bus_trn, pop})
                2'b10:   bus_ocp <= bus_ocp + 1'b1;
                2'b01:   bus_ocp <= bus_ocp - 1'b1;
                default: bus_ocp <= bus_ocp;
            endcase
        end
    end

`ifdef BUS_STR_SERIALIZER_CNT_EN
    logic [15:0] pkt_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (pop) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

    assign str_cnt = pkt_cnt;
`endif

endmodule
